// File: rtl/inst_sequencer.sv
// Instruction issue controller: queues host instructions, decodes them and
// sequences ROWS row-beats of register-file, ALU and host-IO control per instruction.
module inst_sequencer #(
  parameter int ROWS       = 4,
  parameter int PIPE_LAT   = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inst_valid,
  input  logic [31:0]   inst,
  output logic          inst_ready,
  output logic          busy,
  output logic          err,
  output logic [3:0]    rf_ra_addr,
  output logic [3:0]    rf_rb_addr,
  output logic [RW-1:0] rf_row,
  output logic          alu_valid,
  output logic [1:0]    alu_op,
  output logic          rf_we,
  output logic [3:0]    rf_wa,
  output logic [RW-1:0] rf_wrow,
  output logic          rf_wsel,
  output logic          io_wr_beat,
  output logic          io_rd_beat
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [7:0] op;
    logic [3:0] dst;
    logic [3:0] src1;
    logic [3:0] src2;
  } entry_t;

  typedef enum logic [1:0] {KIND_ILL, KIND_IOW, KIND_IOR, KIND_ALU} kind_t;
  typedef enum logic [1:0] {IDLE, BEAT, STALL} state_t;

  function automatic kind_t decode(input entry_t e);
    if (e.op == 8'h00 && e.dst != 4'd0 && e.src1 == 4'd0)
      return KIND_IOW;
    if (e.op == 8'h00 && e.dst == 4'd0 && e.src1 != 4'd0)
      return KIND_IOR;
    if ((e.op == 8'h01 || e.op == 8'h02) && e.dst != 4'd0 && e.src1 != 4'd0 && e.src2 != 4'd0)
      return KIND_ALU;
    return KIND_ILL;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  entry_t              mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  state_t              state;
  logic [RW-1:0]       b;
  logic [PIPE_LAT-1:0] wb_vld_p;
  logic [3:0]          wb_dst_p [PIPE_LAT];
  logic [RW-1:0]       wb_row_p [PIPE_LAT];

  entry_t head;
  kind_t  kind;
  logic   has_head, hazard, beat_act, last_beat, push, pop;
  logic   unused_inst;

  assign unused_inst = ^inst[11:0];
  assign head        = mem[rd_ptr];
  assign kind        = decode(head);
  assign has_head    = (count != '0);
  assign inst_ready  = !rst && (count != CW'(FIFO_DEPTH));
  assign push        = inst_valid && inst_ready;
  assign last_beat   = (b == RW'(ROWS - 1));
  assign busy        = has_head || (|wb_vld_p);

  // Pending write-backs are compared against the head before its first beat.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < PIPE_LAT; i++) begin
      if (wb_vld_p[i]) begin
        if (kind == KIND_IOW)
          hazard = 1'b1;
        if ((kind == KIND_IOR || kind == KIND_ALU) &&
            (wb_dst_p[i] == head.src1 || wb_dst_p[i] == head.src2))
          hazard = 1'b1;
        if (kind == KIND_ALU && wb_dst_p[i] == head.dst)
          hazard = 1'b1;
      end
    end
  end

  assign beat_act = has_head && (kind != KIND_ILL) && (state == BEAT || !hazard);
  assign pop      = has_head && ((kind == KIND_ILL) || (beat_act && last_beat));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      state    <= IDLE;
      b        <= '0;
      err      <= 1'b0;
      wb_vld_p <= '0;
    end else begin
      if (push)
        wr_ptr <= ptr_inc(wr_ptr);
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)
        count <= count + CW'(1);
      else if (!push && pop)
        count <= count - CW'(1);
      if (has_head && kind == KIND_ILL)
        err <= 1'b1;
      if (beat_act) begin
        if (last_beat) begin
          state <= IDLE;
          b     <= '0;
        end else begin
          state <= BEAT;
          b     <= b + RW'(1);
        end
      end else if (has_head && kind != KIND_ILL) begin
        state <= STALL;
      end else begin
        state <= IDLE;
      end
      for (int i = PIPE_LAT - 1; i > 0; i--)
        wb_vld_p[i] <= wb_vld_p[i-1];
      wb_vld_p[0] <= beat_act && (kind == KIND_ALU);
    end
  end

  // Write-back stages: read beat enters stage 0, leaves stage PIPE_LAT-1 as a write.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= entry_t'(inst[31:12]);
    for (int i = PIPE_LAT - 1; i > 0; i--) begin
      wb_dst_p[i] <= wb_dst_p[i-1];
      wb_row_p[i] <= wb_row_p[i-1];
    end
    wb_dst_p[0] <= head.dst;
    wb_row_p[0] <= b;
  end

  always_comb begin
    rf_ra_addr = '0;
    rf_rb_addr = '0;
    rf_row     = '0;
    alu_valid  = 1'b0;
    alu_op     = '0;
    rf_we      = 1'b0;
    rf_wa      = '0;
    rf_wrow    = '0;
    rf_wsel    = 1'b0;
    io_wr_beat = 1'b0;
    io_rd_beat = 1'b0;
    if (beat_act) begin
      case (kind)
        KIND_IOW: begin
          rf_we      = 1'b1;
          rf_wa      = head.dst;
          rf_wrow    = b;
          rf_wsel    = 1'b1;
          io_wr_beat = 1'b1;
        end
        KIND_IOR: begin
          rf_ra_addr = head.src1;
          rf_row     = b;
          io_rd_beat = 1'b1;
        end
        KIND_ALU: begin
          rf_ra_addr = head.src1;
          rf_rb_addr = head.src2;
          rf_row     = b;
          alu_valid  = 1'b1;
          alu_op     = head.op[1:0];
        end
        default: ;
      endcase
    end
    if (wb_vld_p[PIPE_LAT-1]) begin
      rf_we   = 1'b1;
      rf_wa   = wb_dst_p[PIPE_LAT-1];
      rf_wrow = wb_row_p[PIPE_LAT-1];
      rf_wsel = 1'b0;
    end
  end

endmodule

// File: doc/inst_sequencer.md
Name: inst_sequencer

Overview:
- Issue controller between the host instruction port and the 4x64-bit register file and elementwise ALU pipeline.
- Buffers incoming 32-bit instructions in a small FIFO and decodes them.
- Sequences each instruction as ROWS row-beats of read, write and ALU control.
- Holds issue on register hazards against in-flight ALU write-backs.

Parameters:
ROWS, 4, row-beats per instruction; row index width RW = clog2(ROWS)
PIPE_LAT, 2, ALU latency in cycles, from read beat to its write-back beat (>=1)
FIFO_DEPTH, 4, instruction queue entries

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
inst_valid  in  1  host instruction valid
inst  in  32  [31:24] op, [23:20] dst, [19:16] src1, [15:12] src2; register 0 = none
inst_ready  out  1  queue can accept
busy  out  1  queue non-empty, or issuing, or write-back pending
err  out  1  sticky illegal-instruction flag
rf_ra_addr  out  4  read port A register
rf_rb_addr  out  4  read port B register
rf_row  out  RW  read row
alu_valid  out  1  ALU input beat valid
alu_op  out  2  1=ADD, 2=MUL
rf_we  out  1  write enable
rf_wa  out  4  write register
rf_wrow  out  RW  write row
rf_wsel  out  1  write data source: 0=ALU, 1=host data_in
io_wr_beat  out  1  host must present row rf_wrow this cycle
io_rd_beat  out  1  read port A row is valid host output this cycle

Behaviour:
- Reset: all outputs 0 (inst_ready 0 while rst is high); queue, beat counter and write-back pipeline cleared; err cleared. Reset mid-instruction drops all in-flight writes immediately.
- Accept: on inst_valid && inst_ready. inst_ready = !full, registered count, no bypass. A push and a pop in the same cycle are both allowed.
- Issue:
  - Head is eligible the cycle after it is written.
  - States: IDLE, BEAT, STALL.
  - A beat counter b runs 0..ROWS-1 in BEAT.
  - Head is popped in the cycle of beat ROWS-1, so the next eligible instruction starts beat 0 in the following cycle (zero bubbles).
- Decode:
  - op 0x00, dst!=0, src1==0 (IO write): per beat rf_we=1, rf_wa=dst, rf_wrow=b, rf_wsel=1, io_wr_beat=1.
  - op 0x00, dst==0, src1!=0 (IO read): per beat rf_ra_addr=src1, rf_row=b, io_rd_beat=1.
  - op 0x01/0x02 with dst, src1, src2 all !=0 (ADD/MUL): per beat rf_ra_addr=src1, rf_rb_addr=src2, rf_row=b, alu_valid=1, alu_op=op[1:0]. A write-back entry {dst,b} enters a PIPE_LAT-deep shift pipeline and emerges PIPE_LAT cycles later as rf_we=1, rf_wa=dst, rf_wrow=b, rf_wsel=0.
  - Anything else is illegal: err<=1, popped in one cycle, no other outputs.
- Hazards (checked on the head before beat 0; STALL until clear, re-checked every cycle):
  - ADD/MUL or IO read stalls while any pending write-back targets src1 or src2, or dst (ADD/MUL only).
  - IO write stalls while the write-back pipeline is non-empty (write-port conflict plus WAW).
  - Pending writes are taken from the pipeline contents plus the current instruction's remaining beats.
- Idle defaults: addresses, rows, strobes and alu_op drive 0.
- Writes from consecutive ALU instructions never collide, because read beats and write beats are equally spaced.

Test Plan:
1. Reset, push 0x00100000 (IO write r1) at cycle t -> rf_we/io_wr_beat/rf_wsel=1, rf_wa=1, rf_wrow 0,1,2,3 at t+1..t+4; busy falls at t+5.
2. IO write r1, then IO read 0x00010000 back-to-back -> io_rd_beat at t+5..t+8 with rf_ra_addr=1, rf_row 0..3, no stall.
3. Push ADD 0x01312000, then IO read r3 -> alu_valid t+1..t+4; rf_we wa=3, wsel=0 at t+3..t+6; read r3 stalls, first io_rd_beat at t+7.
4. ADD r3=r1+r2, then MUL 0x02412000 -> MUL beats t+5..t+8 with alu_op=2; rf_we high continuously t+3..t+10 (wa 3 then 4).
5. Push 6 IO writes back-to-back -> inst_ready deasserts when 4 are held; all 6 retire in order, 24 write beats, no gaps.
6. Push illegal 0x7F000000, then IO write r2 -> err=1 and stays 1, no rf_we for the illegal one, IO write runs normally. Assert rst mid-ADD -> rf_we, alu_valid and err drop immediately; queue empty after reset.
